// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone prefix adder/subtractor with optional per-level pipeline registers.
// The carry-in column is folded into bit 0 at g/p generation, so LEVELS levels cover every column.
module pipelined_prefix_adder #(
  parameter int  WIDTH     = 8,
  parameter bit  PIPELINED = 1'b1,
  localparam int LEVELS    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Handshake: a beat moves on an edge where valid && ready on that side. The whole pipe
  // advances together on adv; in_ready == adv, so a stalled output freezes every stage.
  logic             adv;
  logic [WIDTH-1:0] b_eff, g_in, p_in, gc;
  logic             c_eff;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub | cin;
  assign p_in     = a ^ b_eff;
  assign g_in     = (a & b_eff) | {{(WIDTH-1){1'b0}}, p_in[0] & c_eff};

  for (genvar k = 0; k <= LEVELS; k++) begin : g_st
    logic [WIDTH-1:0] g, g_n, praw, praw_n;
    logic             c, c_n, v, v_n;

    if (k == 0) begin : g_src
      assign g_n    = g_in;
      assign praw_n = p_in;
      assign c_n    = c_eff;
      assign v_n    = in_valid;
    end else begin : g_src
      localparam int D = 1 << (k - 1);
      assign g_n    = g_st[k-1].g | (g_st[k-1].g_pp.p & (g_st[k-1].g << D));
      assign praw_n = g_st[k-1].praw;
      assign c_n    = g_st[k-1].c;
      assign v_n    = g_st[k-1].v;
    end

    // Group propagate is not needed once the last level has been applied.
    if (k < LEVELS) begin : g_pp
      logic [WIDTH-1:0] p, p_n;
      if (k == 0) begin : g_pn
        assign p_n = {p_in[WIDTH-1:1], 1'b0};
      end else begin : g_pn
        localparam int D = 1 << (k - 1);
        localparam logic [WIDTH-1:0] MASK = ~({WIDTH{1'b1}} << D);
        assign p_n = g_st[k-1].g_pp.p & ((g_st[k-1].g_pp.p << D) | MASK);
      end
      if (PIPELINED) begin : g_reg
        always_ff @(posedge clk) begin
          if (adv) p <= p_n;
        end
      end else begin : g_wire
        assign p = p_n;
      end
    end

    if (PIPELINED) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          v <= 1'b0;
        end else if (adv) begin
          v    <= v_n;
          g    <= g_n;
          praw <= praw_n;
          c    <= c_n;
        end
      end
    end else begin : g_wire
      assign v    = v_n;
      assign g    = g_n;
      assign praw = praw_n;
      assign c    = c_n;
    end
  end

  assign gc = g_st[LEVELS].g;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= g_st[LEVELS].v;
      if (g_st[LEVELS].v) begin
        sum  <= g_st[LEVELS].praw ^ {gc[WIDTH-2:0], g_st[LEVELS].c};
        cout <= gc[WIDTH-1];
        ovf  <= gc[WIDTH-1] ^ gc[WIDTH-2];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: three instances (8/pipelined, 16/combinational, 32/pipelined)
// sharing one driver; sel picks the instance that is driven and observed.
module tb_pipelined_prefix_adder;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  sel = 2'd0;
  int          ready_mode = 0;
  int          pat_idx = 0;
  bit          lat_chk = 1'b1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic [33:0] exp_q[$];
  int          acc_q[$];

  logic        rdy8, v8, c8, o8;
  logic [7:0]  s8;
  logic        rdy16, v16, c16, o16;
  logic [15:0] s16;
  logic        rdy32, v32, c32, o32;
  logic [31:0] s32;
  logic        obs_rdy, obs_valid;
  logic [33:0] obs_data;

  pipelined_prefix_adder #(.WIDTH(8), .PIPELINED(1'b1)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 2'd0), .in_ready(rdy8),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin), .sub(sub), .out_valid(v8),
    .out_ready(sel != 2'd0 || out_ready), .sum(s8), .cout(c8), .ovf(o8));

  pipelined_prefix_adder #(.WIDTH(16), .PIPELINED(1'b0)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 2'd1), .in_ready(rdy16),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin), .sub(sub), .out_valid(v16),
    .out_ready(sel != 2'd1 || out_ready), .sum(s16), .cout(c16), .ovf(o16));

  pipelined_prefix_adder #(.WIDTH(32), .PIPELINED(1'b1)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel == 2'd2), .in_ready(rdy32),
    .a(a_in), .b(b_in), .cin(cin), .sub(sub), .out_valid(v32),
    .out_ready(sel != 2'd2 || out_ready), .sum(s32), .cout(c32), .ovf(o32));

  always_comb begin
    obs_rdy   = rdy8;
    obs_valid = v8;
    obs_data  = {o8, c8, 24'h0, s8};
    case (sel)
      2'd1: begin obs_rdy = rdy16; obs_valid = v16; obs_data = {o16, c16, 16'h0, s16}; end
      2'd2: begin obs_rdy = rdy32; obs_valid = v32; obs_data = {o32, c32, s32}; end
      default: ;
    endcase
  end

  // ---- clock / reset ----
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  // ---- helpers ----
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic int lat_of(input logic [1:0] s);
    case (s)
      2'd0:    return 5;
      2'd1:    return 1;
      default: return 7;
    endcase
  endfunction

  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
    logic [31:0] be;
    logic [32:0] full;
    logic        v;
    be   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + 33'(s | c);
    v    = (a[31] == be[31]) && (full[31] != a[31]);
    return {v, full[32], full[31:0]};
  endfunction

  function automatic vec_t mk(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                              input logic c, input logic su, input logic [31:0] r,
                              input logic co, input logic ov);
    vec_t v;
    v.sel = s; v.a = a; v.b = b; v.cin = c; v.sub = su; v.sum = r; v.cout = co; v.ovf = ov;
    return v;
  endfunction

  // ---- driver tasks (entered and left at posedge+1) ----
  task automatic send(input vec_t v);
    bit accepted;
    a_in = v.a; b_in = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (obs_rdy) accepted = 1'b1;
    end
    if (accepted) begin
      exp_q.push_back({v.ovf, v.cout, v.sum});
      acc_q.push_back(cyc);
    end else begin
      n_chk++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 100 cycles, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_out_valid", 64'(obs_valid), 64'd0);
    check("rst_out_data", 64'(obs_data), 64'd0);
    check("rst_in_ready", 64'(obs_rdy), 64'd1);
  endtask

  // ---- downstream ready driver ----
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = pat[pat_idx % 6]; pat_idx++; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---- scoreboard / monitor (mid-cycle) ----
  bit          stall_prev = 1'b0;
  logic [33:0] prev_data = '0;
  logic [33:0] e;
  int          t;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", 64'(obs_rdy), 64'(!obs_valid || out_ready));
      if (stall_prev) check("stall_hold", 64'({obs_valid, obs_data}), 64'({1'b1, prev_data}));
      if (obs_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_out: got %0h, expected no result", obs_data);
        end else begin
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          check("result", 64'(obs_data), 64'(e));
          if (lat_chk) check("latency", 64'(cyc - t), 64'(lat_of(sel)));
        end
      end
      stall_prev = obs_valid && !out_ready;
      prev_data  = obs_data;
    end
  end

  // ---- test sequence ----
  initial begin
    vec_t tbl [21];
    vec_t rv;
    tbl[0]  = mk(2'd0, 32'h0F, 32'hFF, 1'b0, 1'b0, 32'h0E, 1'b1, 1'b0);
    tbl[1]  = mk(2'd0, 32'hFF, 32'hFF, 1'b0, 1'b0, 32'hFE, 1'b1, 1'b0);
    tbl[2]  = mk(2'd0, 32'h7F, 32'h00, 1'b1, 1'b0, 32'h80, 1'b0, 1'b1);
    tbl[3]  = mk(2'd0, 32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1);
    tbl[4]  = mk(2'd0, 32'h02, 32'h03, 1'b0, 1'b1, 32'hFF, 1'b0, 1'b0);
    tbl[5]  = mk(2'd0, 32'h80, 32'h01, 1'b1, 1'b1, 32'h7F, 1'b1, 1'b1);
    tbl[6]  = mk(2'd0, 32'h00, 32'h01, 1'b0, 1'b0, 32'h01, 1'b0, 1'b0);
    tbl[7]  = mk(2'd0, 32'h01, 32'h01, 1'b0, 1'b0, 32'h02, 1'b0, 1'b0);
    tbl[8]  = mk(2'd0, 32'h01, 32'h02, 1'b0, 1'b0, 32'h03, 1'b0, 1'b0);
    tbl[9]  = mk(2'd0, 32'h02, 32'h02, 1'b0, 1'b0, 32'h04, 1'b0, 1'b0);
    tbl[10] = mk(2'd0, 32'h02, 32'h03, 1'b0, 1'b0, 32'h05, 1'b0, 1'b0);
    tbl[11] = mk(2'd0, 32'h03, 32'h03, 1'b0, 1'b0, 32'h06, 1'b0, 1'b0);
    tbl[12] = mk(2'd0, 32'h03, 32'h04, 1'b0, 1'b0, 32'h07, 1'b0, 1'b0);
    tbl[13] = mk(2'd0, 32'h04, 32'h04, 1'b0, 1'b0, 32'h08, 1'b0, 1'b0);
    tbl[14] = mk(2'd0, 32'h04, 32'h05, 1'b0, 1'b0, 32'h09, 1'b0, 1'b0);
    tbl[15] = mk(2'd0, 32'h00, 32'hFF, 1'b0, 1'b0, 32'hFF, 1'b0, 1'b0);
    tbl[16] = mk(2'd1, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0);
    tbl[17] = mk(2'd1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1);
    tbl[18] = mk(2'd1, 32'h0000, 32'h0001, 1'b0, 1'b1, 32'hFFFF, 1'b0, 1'b0);
    tbl[19] = mk(2'd2, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tbl[20] = mk(2'd2, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    do_reset();

    // directed 8-bit vectors, back-to-back, latency checked
    for (int i = 0; i <= 5; i++) send(tbl[i]);
    drain();

    // streaming under the 1,0,0,1,1,0 out_ready pattern
    ready_mode = 1;
    lat_chk = 1'b0;
    for (int i = 6; i <= 15; i++) send(tbl[i]);
    drain();
    ready_mode = 0;
    lat_chk = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset while three beats are in flight; none of them may surface
    for (int i = 0; i <= 2; i++) send(tbl[i]);
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    send(tbl[3]);
    drain();

    // 16-bit combinational core
    sel = 2'd1;
    for (int i = 16; i <= 18; i++) send(tbl[i]);
    drain();

    // 32-bit pipelined core
    sel = 2'd2;
    for (int i = 19; i <= 20; i++) send(tbl[i]);
    drain();

    // random beats with random out_ready and idle gaps
    ready_mode = 2;
    lat_chk = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      rv.sel = 2'd2;
      rv.a   = $urandom;
      rv.b   = $urandom;
      rv.cin = 1'($urandom_range(0, 1));
      rv.sub = 1'($urandom_range(0, 1));
      {rv.ovf, rv.cout, rv.sum} = model32(rv.a, rv.b, rv.cin, rv.sub);
      send(rv);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    ready_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
Parametrised, pipelined Kogge-Stone prefix adder/subtractor. It is the successor to the 8-bit combinational prefix adder. Width is generic, and each prefix level can optionally be registered. A valid/ready handshake on both sides gives full backpressure. Add/subtract mode and signed-overflow detection are selected per transaction, so the block can feed the ALU datapath directly at high clock rates.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..64.
PIPELINED, 1, 1 = register after g/p generation and after every prefix level; 0 = combinational core with a single output register.
LEVELS, clog2(WIDTH), number of prefix levels; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand beat present
in_ready  output  1  block accepts a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (column -1 generate); ignored when sub=1
sub  input  1  1 = compute a - b
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (for subtract, 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: out_valid=0, sum=0, cout=0, ovf=0. All internal valid bits clear. in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation: every in-flight beat is discarded. No result for those beats ever appears.
- Operand conditioning: b_eff = sub ? ~b : b; c_eff = sub ? 1 : cin.
- Column -1: g = c_eff, p = 0.
- Per bit: g_i = a_i & b_eff_i, p_i = a_i ^ b_eff_i.
- Prefix operator: (G,P)o(G',P') = (G | P&G', P&P'). Level k combines with the column 2^k below; columns below -1 pass through unchanged.
- Result: sum_i = p_i ^ Gc_(i-1); cout = Gc_(WIDTH-1); ovf = Gc_(WIDTH-1) ^ Gc_(WIDTH-2).
- Stage count: PIPELINED=1 gives S = LEVELS+2 stages: g/p register, one register per prefix level, output register. PIPELINED=0 gives S = 1.
- Latency: exactly S cycles from the accept edge to out_valid, with no stalls. For WIDTH=8, PIPELINED=1: latency 5.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stall rule: global enable adv = !out_valid || out_ready; in_ready = adv.
- When adv=0: every stage register and valid bit holds, and sum/cout/ovf stay stable.
- Bubbles: not compressed. Bubbles travel with the pipeline.
- Throughput: one beat per cycle while out_ready=1.
- Output hold: out_valid and its data hold until accepted. out_valid deasserts after acceptance only if no valid beat advances behind it.
- Back-to-back: the output register is overwritten in the same cycle it is accepted. No dead cycle.
- Ordering: results emerge strictly in input order. No beat is lost or duplicated under any out_ready pattern.
- Mode capture: sub and cin are captured with the operands. A mode change between beats affects only the later beat.
- in_valid with in_ready=0: no capture. The source must hold the beat.
- Wrap-around: the sum is modulo 2^WIDTH. Carry beyond the MSB appears only on cout.

Test Plan:
- Add, WIDTH=8, PIPELINED=1, out_ready=1: a=0x0F,b=0xFF,cin=0 -> sum=0x0E, cout=1, ovf=0, 5 cycles after accept. Then a=0xFF,b=0xFF -> sum=0xFE, cout=1.
- Carry-in and overflow: a=0x7F,b=0x00,cin=1 -> sum=0x80, cout=0, ovf=1. Then a=0x80,b=0x80,cin=0 -> sum=0x00, cout=1, ovf=1.
- Subtract with ignored cin: a=0x02,b=0x03,sub=1,cin=0 -> sum=0xFF, cout=0, ovf=0. Then a=0x80,b=0x01,sub=1 -> sum=0x7F, cout=1, ovf=1.
- Streaming with backpressure: 10 beats {0x00+0x01, 0x01+0x01, 0x01+0x02, ... 0x00+0xFF}, out_ready pattern 1,0,0,1,1,0,... -> results in order (0x01, 0x02, 0x03, ... 0xFF). in_ready low exactly when out_valid && !out_ready. Data stable while stalled. No loss or duplication.
- Reset mid-flight: issue 3 beats, assert reset for 1 cycle while they are in flight -> out_valid=0 the next cycle and none of the 3 results ever appear. A new beat issued after reset returns after 5 cycles.
- Generics: WIDTH=16, PIPELINED=0 -> latency 1, 0xFFFF+0x0001 -> sum=0x0000, cout=1. WIDTH=32, PIPELINED=1 -> latency 7. 1000 random beats checked against a + b_eff + c_eff, with random out_ready.
